// File: rtl/mac_pkg.sv
// Shared definitions for the MAC datapath and the blocks that accumulate with it.
package mac_pkg;

    localparam int MAC_DATA_W = 8;
    localparam int MAC_ACC_W  = 2 * MAC_DATA_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Signed-add overflow: both addends share a sign and the sum's sign differs.
    function automatic logic add_ovf(input logic prod_sign,
                                     input logic acc_sign,
                                     input logic sum_sign);
        return (prod_sign == acc_sign) && (sum_sign != prod_sign);
    endfunction

endpackage

// File: rtl/mac_dot_engine_if.sv
// Operand-in and result-out valid/ready channels of the dot-product engine.
interface mac_dot_engine_if #(
    parameter int DATA_W = 8
);
    logic                         in_valid;
    logic                         in_ready;
    logic signed [DATA_W-1:0]     in_a;
    logic signed [DATA_W-1:0]     in_b;
    logic                         out_valid;
    logic                         out_ready;
    logic signed [2*DATA_W-1:0]   out_acc;
    logic                         out_ovf;

    // Operand source / result consumer side.
    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_acc, out_ovf
    );

    // Engine side.
    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_acc, out_ovf
    );
endinterface

// File: rtl/mac.sv
// Combinational multiply-accumulate: y = a*b + c, full-precision product, wrapping sum.
module mac #(
    parameter int DATA_W = 8
) (
    input  logic signed [DATA_W-1:0]   a,
    input  logic signed [DATA_W-1:0]   b,
    input  logic signed [2*DATA_W-1:0] c,
    output logic signed [2*DATA_W-1:0] prod,
    output logic signed [2*DATA_W-1:0] y
);

    assign prod = a * b;
    assign y    = prod + c;

endmodule

// File: rtl/mac_dot_engine.sv
// Sequential dot-product engine: streams operand pairs through mac, feeding y back as c.
module mac_dot_engine
    import mac_pkg::*;
#(
    parameter int DATA_W = MAC_DATA_W,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  cfg_len,
    output logic              busy,
    mac_dot_engine_if.slave   bus
);

    localparam int ACC_W = 2 * DATA_W;

    state_t                    state;
    logic signed [ACC_W-1:0]   acc;
    logic [LEN_W-1:0]          count;
    logic                      ovf;
    logic                      out_valid_q;
    logic signed [ACC_W-1:0]   prod;
    logic signed [ACC_W-1:0]   y;
    logic                      beat;

    mac #(DATA_W) u_mac (
        .a    (bus.in_a),
        .b    (bus.in_b),
        .c    (acc),
        .prod (prod),
        .y    (y)
    );

    assign bus.in_ready  = (state == RUN);
    assign beat          = bus.in_valid && (state == RUN);
    assign bus.out_valid = out_valid_q;
    assign bus.out_acc   = acc;
    assign bus.out_ovf   = ovf;

    // Control FSM, beat counter, accumulator and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= '0;
            count       <= '0;
            ovf         <= 1'b0;
            busy        <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc  <= '0;
                        ovf  <= 1'b0;
                        busy <= 1'b1;
                        if (cfg_len != '0) begin
                            count <= cfg_len;
                            state <= RUN;
                        end else begin
                            state       <= DONE;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (beat) begin
                        acc   <= y;
                        ovf   <= ovf | add_ovf(prod[ACC_W-1], acc[ACC_W-1], y[ACC_W-1]);
                        count <= count - 1'b1;
                        if (count == LEN_W'(1)) begin
                            state       <= DONE;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        busy        <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    out_valid_q <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_dot_engine.sv
// Directed self-checking bench for mac_dot_engine.
module tb_mac_dot_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] cfg_len;
    logic       busy;
    int         tests = 0;
    int         fails = 0;

    mac_dot_engine_if #(.DATA_W(8)) bus ();

    mac_dot_engine #(.DATA_W(8), .LEN_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .cfg_len (cfg_len),
        .busy    (busy),
        .bus     (bus)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] len);
        start   = 1'b1;
        cfg_len = len;
        tick();
        start   = 1'b0;
    endtask

    task automatic beat(input logic signed [7:0] a, input logic signed [7:0] b);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        tests++;
        if (!bus.in_ready) begin
            fails++;
            $display("FAIL beat_timeout: in_ready=%0b required 1", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if ({busy, bus.in_ready, bus.out_valid, bus.out_ovf} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_flags: busy/in_ready/out_valid/out_ovf=%b required 0000",
                     {busy, bus.in_ready, bus.out_valid, bus.out_ovf});
        end
        tests++;
        if (bus.out_acc !== 16'sd0) begin
            fails++;
            $display("FAIL reset_acc: out_acc=%0d required 0", $signed(bus.out_acc));
        end
    endtask

    task automatic test_basic();
        bus.out_ready = 1'b1;
        do_start(8'd2);
        beat(8'sd5, -8'sd3);
        tests++;
        if (bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL basic_early_valid: out_valid=%0b required 0", bus.out_valid);
        end
        beat(8'sd12, 8'sd9);
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_acc !== 16'sd93 || bus.out_ovf !== 1'b0) begin
            fails++;
            $display("FAIL basic_result: valid=%0b acc=%0d ovf=%0b required 1 93 0",
                     bus.out_valid, $signed(bus.out_acc), bus.out_ovf);
        end
        tick();
        tests++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL basic_handshake: valid=%0b busy=%0b required 0 0", bus.out_valid, busy);
        end
    endtask

    task automatic test_empty();
        bus.out_ready = 1'b0;
        do_start(8'd0);
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_acc !== 16'sd0 || bus.out_ovf !== 1'b0 ||
            bus.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL empty_result: valid=%0b acc=%0d ovf=%0b in_ready=%0b required 1 0 0 0",
                     bus.out_valid, $signed(bus.out_acc), bus.out_ovf, bus.in_ready);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL empty_done: valid=%0b in_ready=%0b required 0 0",
                     bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_overflow();
        bus.out_ready = 1'b0;
        do_start(8'd3);
        for (int i = 0; i < 3; i++) beat(8'sd127, 8'sd127);
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_acc !== 16'(-17149) || bus.out_ovf !== 1'b1) begin
            fails++;
            $display("FAIL ovf_result: valid=%0b acc=%0d ovf=%0b required 1 -17149 1",
                     bus.out_valid, $signed(bus.out_acc), bus.out_ovf);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        do_start(8'd1);
        tests++;
        if (bus.out_ovf !== 1'b0) begin
            fails++;
            $display("FAIL ovf_clear_on_start: ovf=%0b required 0", bus.out_ovf);
        end
        beat(-8'sd128, -8'sd128);
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_acc !== 16'sd16384 || bus.out_ovf !== 1'b0) begin
            fails++;
            $display("FAIL ovf_second: valid=%0b acc=%0d ovf=%0b required 1 16384 0",
                     bus.out_valid, $signed(bus.out_acc), bus.out_ovf);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_stall();
        bus.out_ready = 1'b0;
        do_start(8'd4);
        beat(8'sd1, 8'sd1);
        beat(8'sd2, 8'sd2);
        for (int i = 0; i < 3; i++) begin
            start   = (i == 1);
            cfg_len = 8'd1;
            tick();
        end
        start = 1'b0;
        tests++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b1 || bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL stall_hold: valid=%0b busy=%0b in_ready=%0b required 0 1 1",
                     bus.out_valid, busy, bus.in_ready);
        end
        beat(8'sd3, 8'sd3);
        beat(8'sd4, 8'sd4);
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (bus.out_valid !== 1'b1 || bus.out_acc !== 16'sd30 || bus.out_ovf !== 1'b0) begin
                fails++;
                $display("FAIL stall_result_hold[%0d]: valid=%0b acc=%0d ovf=%0b required 1 30 0",
                         i, bus.out_valid, $signed(bus.out_acc), bus.out_ovf);
            end
            start   = i[0];
            cfg_len = 8'd2;
            tick();
        end
        // Start coinciding with the result handshake must be dropped.
        start         = 1'b1;
        cfg_len       = 8'd2;
        bus.out_ready = 1'b1;
        tick();
        start         = 1'b0;
        bus.out_ready = 1'b0;
        tests++;
        if (busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL stall_start_on_handshake: busy=%0b valid=%0b in_ready=%0b required 0 0 0",
                     busy, bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        do_start(8'd5);
        beat(8'sd10, 8'sd10);
        beat(8'sd10, 8'sd10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if ({busy, bus.in_ready, bus.out_valid, bus.out_ovf} !== 4'b0000 ||
            bus.out_acc !== 16'sd0) begin
            fails++;
            $display("FAIL midrun_reset: flags=%b acc=%0d required 0000 0",
                     {busy, bus.in_ready, bus.out_valid, bus.out_ovf}, $signed(bus.out_acc));
        end
        do_start(8'd1);
        beat(-8'sd7, 8'sd6);
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_acc !== 16'(-42) || bus.out_ovf !== 1'b0) begin
            fails++;
            $display("FAIL after_reset_result: valid=%0b acc=%0d ovf=%0b required 1 -42 0",
                     bus.out_valid, $signed(bus.out_acc), bus.out_ovf);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        cfg_len       = '0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        tick();
        test_reset();
        test_basic();
        test_empty();
        test_overflow();
        test_stall();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
